comb_logic_sweeper: RTL and testbench
=====================================

Name: comb_logic_sweeper

Overview:
Self-test sequencer for the 3-input combinational logic block (inputs A,B,C; output F). It sweeps all 8 input vectors into the block in order, waits a programmable settle time per vector, samples F and compares it against an expected truth table. It reports pass/fail, a mismatch count, a per-vector mismatch mask and the first failing vector. It sits between bring-up control logic and the combinational block, and owns the block's inputs while a sweep runs.

Parameters:
EXP_TT, 8'hDB, expected truth table; bit i = expected F for {A,B,C}=i (bit 5 = 0, i.e. F(1,0,1)=0).
SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range 1..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
start  input  1  begin sweep; accepted only in IDLE
abort  input  1  synchronous cancel of a running sweep
f_in  input  1  F from the combinational block
a_out  output  1  A to the combinational block
b_out  output  1  B to the combinational block
c_out  output  1  C to the combinational block
busy  output  1  high while sweeping (RUN state)
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  1 = last completed sweep had zero mismatches
fail_count  output  4  mismatches in last sweep (0..8)
fail_mask  output  8  bit i set = vector i mismatched
first_fail_vec  output  3  lowest failing vector; 0 when fail_count==0

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs are 0: a/b/c_out, busy, done, pass, fail_count, fail_mask, first_fail_vec. The vector and settle counters clear.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: a/b/c_out=000. When start=1 at a clock edge:
  - go to RUN, set vec=0 and settle_cnt=0;
  - clear pass, fail_count, fail_mask and first_fail_vec;
  - set busy=1.
- RUN: {a_out,b_out,c_out}=vec. settle_cnt increments each cycle.
  - At the edge where settle_cnt==SETTLE_CYCLES-1, sample f_in and compare it with EXP_TT[vec].
  - On mismatch: fail_count+=1, fail_mask[vec]=1. If this is the first mismatch, first_fail_vec=vec.
  - On that same edge, settle_cnt resets to 0 and vec increments.
  - Each vector is therefore driven for exactly SETTLE_CYCLES cycles.
- Completion:
  - The edge that samples vec=7 moves to DONE.
  - In DONE: busy=0, done=1 for exactly one cycle, and pass=(final fail_count==0); pass accounts for a mismatch on vec 7.
  - Next state is IDLE.
- Latency: start edge to done high = 8*SETTLE_CYCLES+1 cycles (17 at default).
- Results (pass, fail_count, fail_mask, first_fail_vec) hold until the next accepted start or reset.
- start while in RUN or DONE is ignored; it is not queued.
- abort=1 in RUN:
  - next state is IDLE, busy=0, a/b/c_out=000;
  - done is not pulsed, pass=0, partial fail_count and fail_mask are retained.
  - abort outside RUN has no effect.
- abort and start asserted together in IDLE: start wins (abort is a don't-care in IDLE).
- Reset asserted mid-sweep: outputs clear immediately, without waiting for a clock edge. The sweep restarts only on a new start.
- fail_count cannot exceed 8, so no saturation logic is needed.
- vec never wraps inside a sweep; vec=7 is terminal.

Test Plan:
- Ideal model (F = EXP_TT[{A,B,C}]), start pulse at t0 -> vectors 000..111 each held 2 cycles; done at t0+17; pass=1, fail_count=0, fail_mask=8'h00, first_fail_vec=0.
- f_in stuck at 0 -> pass=0, fail_count=6, fail_mask=8'hDB, first_fail_vec=0.
- Model with F forced to 1 only at {A,B,C}=101 (checks F(1,0,1)=0) -> fail_count=1, fail_mask=8'h20, first_fail_vec=5, pass=0.
- start re-pulsed in cycles 3 and 10 of a running sweep -> ignored; done still at t0+17, exactly one done pulse.
- abort during vector 3 -> busy low next cycle, a/b/c_out=000, no done pulse, pass=0. A new start then gives a clean sweep with pass=1.
- rst_n low mid-sweep (between clock edges) -> all outputs 0 immediately. After release, stays in IDLE until start.

Source files
------------

// File: rtl/comb_logic_sweeper.sv
// comb_logic_sweeper: self-test sequencer for a 3-input combinational block.
// Walks {A,B,C} through 000..111, holds each vector SETTLE_CYCLES cycles,
// samples F on the last held cycle and scores it against EXP_TT.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | inputs parked at 000, results held, waiting for start
//   RUN     | driving vec, counting settle cycles, scoring F
//   DONE    | one-cycle done pulse with final pass flag, then IDLE
module comb_logic_sweeper #(
    parameter logic [7:0]  EXP_TT        = 8'hDB,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [7:0] fail_mask,
    output logic [2:0] first_fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [2:0] vec_q;
    logic [3:0] settle_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] fail_count_q;
    logic [7:0] fail_mask_q;
    logic [2:0] first_fail_q;

    logic       sample_now;
    logic       mismatch;
    logic [3:0] fail_count_d;

    // Scoring helpers for the sample edge; fail_count_d already includes the
    // current vector so the final pass flag sees a mismatch on vector 7.
    always_comb begin
        sample_now   = (settle_q == SETTLE_LAST);
        mismatch     = (f_in != EXP_TT[vec_q]);
        fail_count_d = fail_count_q + {3'b000, mismatch};
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 3'd0;
            settle_q     <= 4'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 4'd0;
            fail_mask_q  <= 8'h00;
            first_fail_q <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    abc_q <= 3'd0;
                    if (start) begin
                        state_q      <= ST_RUN;
                        vec_q        <= 3'd0;
                        settle_q     <= 4'd0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_count_q <= 4'd0;
                        fail_mask_q  <= 8'h00;
                        first_fail_q <= 3'd0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Partial counts and mask stay visible for debug.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        abc_q   <= 3'd0;
                        pass_q  <= 1'b0;
                    end else if (sample_now) begin
                        settle_q <= 4'd0;
                        if (mismatch) begin
                            fail_count_q       <= fail_count_d;
                            fail_mask_q[vec_q] <= 1'b1;
                            if (fail_count_q == 4'd0) begin
                                first_fail_q <= vec_q;
                            end
                        end
                        if (vec_q == 3'd7) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (fail_count_d == 4'd0);
                            abc_q   <= 3'd0;
                        end else begin
                            vec_q <= vec_q + 3'd1;
                            abc_q <= vec_q + 3'd1;
                        end
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    abc_q   <= 3'd0;
                end
            endcase
        end
    end

    assign a_out          = abc_q[2];
    assign b_out          = abc_q[1];
    assign c_out          = abc_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign fail_mask      = fail_mask_q;
    assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_comb_logic_sweeper.sv
// Bench for comb_logic_sweeper: a behavioural combinational block with a
// programmable truth table feeds f_in; expected sweep results are queued at
// start and scored by an independent monitor on each done pulse.
module tb_comb_logic_sweeper;

    localparam logic [7:0] EXP = 8'hDB;
    localparam int         S   = 2;

    typedef struct packed {
        logic       pass;
        logic [3:0] cnt;
        logic [7:0] mask;
        logic [2:0] first;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       f_in;
    logic       a_out, b_out, c_out, busy, done, pass;
    logic [3:0] fail_count;
    logic [7:0] fail_mask;
    logic [2:0] first_fail_vec;

    logic [7:0] blk_tt = EXP;
    logic [2:0] vin;

    int   n_pass = 0;
    int   n_total = 0;
    int   done_seen = 0;
    res_t exp_q[$];

    comb_logic_sweeper #(.EXP_TT(EXP), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .busy(busy), .done(done),
        .pass(pass), .fail_count(fail_count), .fail_mask(fail_mask),
        .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    assign vin  = {a_out, b_out, c_out};
    assign f_in = blk_tt[vin];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected result of scoring the first n vectors of block table tt.
    function automatic res_t model(input logic [7:0] tt, input int n);
        res_t r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (tt[i] != EXP[i]) begin
                if (r.cnt == 0) r.first = 3'(i);
                r.cnt++;
                r.mask[i] = 1'b1;
            end
        end
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    // Monitor: score every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_busy", {31'd0, busy}, 32'd0);
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("fail_count", {28'd0, fail_count}, {28'd0, e.cnt});
                chk("fail_mask", {24'd0, fail_mask}, {24'd0, e.mask});
                chk("first_fail_vec", {29'd0, first_fail_vec}, {29'd0, e.first});
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk(name, {17'd0, vin, busy, done, pass, fail_count, fail_mask, first_fail_vec}, 32'd0);
    endtask

    // One full sweep; optional start re-pulses mid-run and abort held with start.
    task automatic sweep(input logic [7:0] tt, input bit repulse, input bit abort_too);
        res_t r;
        int   k;
        int   d0;
        bit   got;
        blk_tt = tt;
        r = model(tt, 8);
        exp_q.push_back(r);
        d0 = done_seen;
        @(negedge clk); start = 1'b1; abort = abort_too;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 8 * S + 10) begin
            if (done) begin
                got = 1'b1;
            end else begin
                chk("busy_run", {31'd0, busy}, 32'd1);
                chk("vec_drive", {29'd0, vin}, 32'(k / S));
                start = repulse && (k == 3 || k == 10);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        if (got) chk("latency", 32'(k + 1), 32'(8 * S + 1));
        else     chk("done_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        chk("one_done", 32'(done_seen - d0), 32'd1);
        chk("hold_pass", {31'd0, pass}, {31'd0, r.pass});
        chk("hold_mask", {24'd0, fail_mask}, {24'd0, r.mask});
        chk("idle_abc", {29'd0, vin}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        res_t r;
        int   d0;
        #12;
        check_all_zero("reset_outputs");
        @(negedge clk); rst_n = 1'b1;

        // abort in IDLE does nothing
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);

        sweep(EXP, 1'b0, 1'b0);             // ideal block
        sweep(8'h00, 1'b0, 1'b0);           // F stuck at 0
        sweep(EXP | 8'h20, 1'b0, 1'b0);     // F(1,0,1) wrongly 1
        sweep(EXP ^ 8'h80, 1'b0, 1'b0);     // only the last vector fails
        sweep(EXP, 1'b1, 1'b0);             // start re-pulsed mid-run
        sweep(8'h00, 1'b0, 1'b1);           // abort together with start

        // abort during vector 3 with a stuck-at-0 block
        blk_tt = 8'h00;
        d0 = done_seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3 * S) @(negedge clk);
        chk("abort_at_vec3", {29'd0, vin}, 32'd3);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        r = model(8'h00, 3);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_abc", {29'd0, vin}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        chk("abort_count", {28'd0, fail_count}, {28'd0, r.cnt});
        chk("abort_mask", {24'd0, fail_mask}, {24'd0, r.mask});
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);
        sweep(EXP, 1'b0, 1'b0);

        // asynchronous reset between edges mid-sweep
        blk_tt = 8'h00;
        d0 = done_seen;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2 * 8 * S) @(negedge clk);
        chk("reset_stays_idle", {31'd0, busy}, 32'd0);
        chk("reset_no_done", 32'(done_seen - d0), 32'd0);
        chk("reset_abc", {29'd0, vin}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            sweep(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
